tpumac_pipe: RTL and testbench
==============================

# tpumac_pipe

Parametrised successor to the systolic-array MAC cell. It has configurable operand and accumulator widths, an optional multiplier pipeline, a signed or unsigned mode, saturating or wrapping accumulation, a sticky overflow flag and a synchronous clear. It is the processing element tiled into the next-generation systolic array: A flows east, B flows south, and C holds the partial sum.

## Interface
- BITS_AB, 8: operand width of A and B.
- BITS_C, 16: accumulator width. Must satisfy BITS_C >= 2*BITS_AB; elaboration fails otherwise.
- MUL_STAGES, 0: multiplier pipeline registers, legal range 0..3. 0 gives a combinational multiply, the same as the prior-generation cell.
- SIGNED, 1: 1 selects two's-complement operands and accumulator; 0 selects unsigned.
- SATURATE, 1: 1 clamps on overflow; 0 wraps modulo 2^BITS_C.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  captures Ain/Bin and launches one product.
- WrEn  in  1  preloads the accumulator from Cin.
- clr  in  1  synchronous clear of accumulator, overflow flag and pipeline.
- Ain  in  BITS_AB  A operand.
- Bin  in  BITS_AB  B operand.
- Cin  in  BITS_C  preload value.
- Aout  out  BITS_AB  registered A, forwarded to the east neighbour.
- Bout  out  BITS_AB  registered B, forwarded to the south neighbour.
- Cout  out  BITS_C  accumulator.
- ovf  out  1  sticky overflow flag.
- busy  out  1  at least one product is in flight.

## Operation
- Priority order: rst > clr > WrEn > accumulate.
- en=1: Aout<=Ain and Bout<=Bin. Product P=Ain*Bin (2*BITS_AB bits, extended per SIGNED) enters the pipeline with a valid bit. en=0: Aout and Bout hold, and no product is launched.
- The pipeline advances every cycle, independent of en. Each stage carries {valid, product}.
- Retiring product: a product with its valid bit set leaving the last stage. When MUL_STAGES=0, this is the product launched in the current cycle.
- Accumulate: on a retiring product, sum = Cout + P, computed at BITS_C+1 bits.
  - If sum is outside the BITS_C range: ovf<=1. SATURATE=1 writes the max or min value (signed: 2^(BITS_C-1)-1 / -2^(BITS_C-1); unsigned: 2^BITS_C-1 / 0). SATURATE=0 writes the low BITS_C bits.
- WrEn=1: Cout <= Cin + P_retiring, with the same overflow and saturation rules. If nothing retires, Cout <= Cin. ovf <= the overflow of this add only; the previous sticky value is discarded.
- clr=1: Cout<=0, ovf<=0, all pipeline valid bits cleared, so in-flight products are dropped. Aout/Bout still update if en=1, but the product launched in that cycle is dropped.
- ovf is sticky. Only rst, clr or WrEn clear it.
- busy = OR of the pipeline valid bits. It is always 0 when MUL_STAGES=0.

## Timing
- Reset values: Aout=0, Bout=0, Cout=0, ovf=0, busy=0, all valid bits 0. Reset mid-operation discards all in-flight products. The first edge after rst falls behaves as a normal cycle.
- Aout/Bout: 1-cycle latency from en.
- Cout: if en is sampled at edge k, its product is reflected in Cout after edge k+MUL_STAGES.
- Back-to-back en issues one product per cycle. Cout updates on consecutive edges with no bubbles.
- busy rises after the first launching edge and falls after the edge on which the last product retires.
- WrEn asserted in a cycle with no product in flight matches the prior cell: Cout=Cin after one edge.
- A MAC issued with en in the cycle immediately after WrEn accumulates onto the preloaded value.

## Structure
- Package tpumac_pkg holds:
  - the saturation/range helper function, parametrised by width and signedness;
  - the width-legality check;
  - the typedef for a pipeline stage, {valid, product}.
- Sub-module tpumac_mulpipe: multiplier plus MUL_STAGES-deep register chain, carrying valid and product, with flush on clr or rst.
  - The top level holds the A/B forwarding registers, the accumulator, the saturation logic and the priority logic.

## Test plan
- Reset: rst=1 for 2 cycles with en=1 and WrEn=1 driven -> Aout, Bout, Cout, ovf and busy all remain 0.
- MUL_STAGES=0, signed: WrEn with Cin=100, then en with Ain=3, Bin=-4 -> after next edge Aout=3, Bout=-4, Cout=88, ovf=0.
- Overflow, 16-bit signed: preload 32700, then en with 10*10.
  - SATURATE=1 -> Cout=32767, ovf=1.
  - SATURATE=0 -> Cout=-32736, ovf=1.
  - A following 1*1 keeps ovf=1.
- MUL_STAGES=2: C=0, en for 3 cycles with (1,2), (3,4), (5,6) starting at edge k -> Cout=2, 14, 44 after edges k+2, k+3, k+4; busy=1 from k through k+3 and 0 after k+4.
- Collisions, MUL_STAGES=1:
  - Product 6 retires in the same cycle as WrEn with Cin=50 -> Cout=56.
  - clr asserted with two products in flight -> Cout=0 and busy=0 next edge, with no later update.
- Unsigned mode, SIGNED=0: 255*255 from C=0 -> Cout=65025. A second 255*255 -> Cout=65535, ovf=1 (saturating).

Source files
------------

// File: rtl/tpumac_pkg.sv
// rtl/tpumac_pkg.sv - shared types, limits and helpers for the tpumac processing element
package tpumac_pkg;

  // Products travel the pipeline already extended to this width so the stage
  // type does not depend on the operand width of a particular instance.
  localparam int PROD_W = 64;

  // Accumulate arithmetic is done at this width; it leaves headroom above the
  // widest legal accumulator so the range test never loses the carry.
  localparam int SUM_W = 66;

  // One multiplier pipeline stage: a product and whether it is real.
  typedef struct packed {
    logic              valid;
    logic [PROD_W-1:0] product;
  } mac_stage_t;

  // Legal parameter combinations for the processing element.
  function automatic logic widths_ok(input int bits_ab, input int bits_c, input int mul_stages);
    return (bits_ab > 0) && (bits_c >= 2 * bits_ab) && (bits_c <= SUM_W - 4) &&
           (mul_stages >= 0) && (mul_stages <= 3);
  endfunction

  // Range test of a wide sum against a w-bit accumulator.
  // Returns {above_max, below_min}; both zero means the sum fits.
  function automatic logic [1:0] range_chk(input logic signed [SUM_W-1:0] s,
                                           input int w, input logic sgn);
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    one = SUM_W'(1);
    if (sgn) begin
      hi = (one <<< (w - 1)) - one;
      lo = -(one <<< (w - 1));
    end else begin
      hi = (one <<< w) - one;
      lo = '0;
    end
    return {s > hi, s < lo};
  endfunction

endpackage

// File: rtl/tpumac_mulpipe.sv
// rtl/tpumac_mulpipe.sv - multiplier with an optional valid-tagged register chain
module tpumac_mulpipe
  import tpumac_pkg::*;
#(
  parameter int BITS_AB    = 8,
  parameter int MUL_STAGES = 0,
  parameter int SIGNED     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               en,
  input  logic [BITS_AB-1:0] a,
  input  logic [BITS_AB-1:0] b,
  output logic               ret_valid,
  output logic [PROD_W-1:0]  ret_prod,
  output logic               busy
);

  localparam int PW2 = 2 * BITS_AB;

  logic [PW2-1:0]    p_raw;
  logic [PROD_W-1:0] p_ext;

  // Full-width product, extended to the carrier width according to the mode.
  always_comb begin
    if (SIGNED != 0) begin
      p_raw = PW2'($signed(a)) * PW2'($signed(b));
      p_ext = PROD_W'($signed(p_raw));
    end else begin
      p_raw = PW2'(a) * PW2'(b);
      p_ext = PROD_W'(p_raw);
    end
  end

  if (MUL_STAGES == 0) begin : g_comb
    // No registers: the product launched this cycle retires this cycle.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, flush};
    assign ret_valid = en;
    assign ret_prod  = p_ext;
    assign busy      = 1'b0;
  end else begin : g_pipe
    mac_stage_t st [MUL_STAGES];

    // Advance the chain every cycle; reset and flush drop everything in flight.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i < MUL_STAGES; i++) st[i] <= '0;
      end else begin
        st[0] <= '{valid: en, product: p_ext};
        for (int i = 1; i < MUL_STAGES; i++) st[i] <= st[i-1];
      end
    end

    // Anything valid anywhere in the chain counts as in flight.
    always_comb begin
      busy = 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) busy = busy | st[i].valid;
    end

    assign ret_valid = st[MUL_STAGES-1].valid;
    assign ret_prod  = st[MUL_STAGES-1].product;
  end

endmodule

// File: rtl/tpumac_pipe.sv
// rtl/tpumac_pipe.sv - parametrised systolic MAC processing element
module tpumac_pipe
  import tpumac_pkg::*;
#(
  parameter int BITS_AB    = 8,
  parameter int BITS_C     = 16,
  parameter int MUL_STAGES = 0,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               WrEn,
  input  logic               clr,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]  Cout,
  output logic               ovf,
  output logic               busy
);

  if (!widths_ok(BITS_AB, BITS_C, MUL_STAGES)) begin : g_width_bad
    $error("tpumac_pipe: illegal BITS_AB / BITS_C / MUL_STAGES combination");
  end

  localparam logic [BITS_C-1:0] C_MAX = (SIGNED != 0) ? {1'b0, {(BITS_C-1){1'b1}}}
                                                      : {BITS_C{1'b1}};
  localparam logic [BITS_C-1:0] C_MIN = (SIGNED != 0) ? {1'b1, {(BITS_C-1){1'b0}}}
                                                      : {BITS_C{1'b0}};

  logic                    ret_valid;
  logic [PROD_W-1:0]       ret_prod;
  logic [BITS_C-1:0]       base;
  logic signed [SUM_W-1:0] c_ext;
  logic signed [SUM_W-1:0] p_ext;
  logic signed [SUM_W-1:0] sum;
  logic [1:0]              rng;
  logic [BITS_C-1:0]       fit;
  logic                    add_of;
  logic [BITS_C-1:0]       c_nxt;
  logic                    ovf_nxt;

  tpumac_mulpipe #(
    .BITS_AB    (BITS_AB),
    .MUL_STAGES (MUL_STAGES),
    .SIGNED     (SIGNED)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .flush     (clr),
    .en        (en),
    .a         (Ain),
    .b         (Bin),
    .ret_valid (ret_valid),
    .ret_prod  (ret_prod),
    .busy      (busy)
  );

  // Forward the operands to the east and south neighbours on every launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
    end
  end

  // One adder serves both preload and accumulate; the base switches to Cin on WrEn.
  always_comb begin
    base = WrEn ? Cin : Cout;
    if (SIGNED != 0) c_ext = SUM_W'($signed(base));
    else             c_ext = SUM_W'(base);
    p_ext = ret_valid ? SUM_W'($signed(ret_prod)) : '0;
    sum   = c_ext + p_ext;
    rng   = range_chk(sum, BITS_C, SIGNED != 0);
    add_of = |rng;
    if (rng[1])      fit = (SATURATE != 0) ? C_MAX : sum[BITS_C-1:0];
    else if (rng[0]) fit = (SATURATE != 0) ? C_MIN : sum[BITS_C-1:0];
    else             fit = sum[BITS_C-1:0];
  end

  // Priority clr > WrEn > accumulate; a preload restarts the sticky flag.
  always_comb begin
    c_nxt   = Cout;
    ovf_nxt = ovf;
    if (clr) begin
      c_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (WrEn) begin
      c_nxt   = fit;
      ovf_nxt = add_of;
    end else if (ret_valid) begin
      c_nxt   = fit;
      ovf_nxt = ovf | add_of;
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cout <= '0;
      ovf  <= 1'b0;
    end else begin
      Cout <= c_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_tpumac_pipe.sv
// tb/tb_tpumac_pipe.sv - bench for five tpumac_pipe configurations sharing one stimulus
module tb_tpumac_pipe;

  localparam int N = 5;
  // 0: comb signed sat, 1: comb signed wrap, 2: 2-stage, 3: 1-stage, 4: comb unsigned sat
  localparam int MS [N] = '{0, 0, 2, 1, 0};
  localparam int SG [N] = '{1, 1, 1, 1, 0};
  localparam int ST [N] = '{1, 0, 1, 1, 1};

  logic        clk;
  logic        rst, en, WrEn, clr;
  logic [7:0]  Ain, Bin;
  logic [15:0] Cin;
  logic [7:0]  aout [N];
  logic [7:0]  bout [N];
  logic [15:0] cout [N];
  logic        ovf  [N];
  logic        busy [N];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state
  longint m_acc [N];
  bit     m_ovf [N];
  bit [7:0] m_a, m_b;
  bit     pv   [N][4];
  int     pdue [N][4];
  longint pp   [N][4];
  int     cyc = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    tpumac_pipe #(
      .BITS_AB(8), .BITS_C(16), .MUL_STAGES(MS[g]), .SIGNED(SG[g]), .SATURATE(ST[g])
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr),
      .Ain(Ain), .Bin(Bin), .Cin(Cin),
      .Aout(aout[g]), .Bout(bout[g]), .Cout(cout[g]), .ovf(ovf[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic longint prod_of(int g);
    if (SG[g] != 0) return longint'($signed(Ain)) * longint'($signed(Bin));
    return longint'(Ain) * longint'(Bin);
  endfunction

  function automatic longint cin_of(int g);
    if (SG[g] != 0) return longint'($signed(Cin));
    return longint'(Cin);
  endfunction

  function automatic longint fit(input longint s, input int g, output bit of);
    longint hi, lo, w;
    hi = (SG[g] != 0) ? 32767 : 65535;
    lo = (SG[g] != 0) ? -32768 : 0;
    of = (s > hi) || (s < lo);
    if (!of) return s;
    if (ST[g] != 0) return (s > hi) ? hi : lo;
    w = s & 65535;
    if (SG[g] != 0 && w > 32767) w = w - 65536;
    return w;
  endfunction

  // model of one clock edge: products scheduled by due cycle, plain arithmetic on the sum
  function automatic void model_edge();
    for (int g = 0; g < N; g++) begin
      bit ret, of;
      longint rp;
      ret = 0; rp = 0; of = 0;
      if (rst) begin
        for (int k = 0; k < 4; k++) pv[g][k] = 0;
        m_acc[g] = 0; m_ovf[g] = 0;
      end else begin
        if (en && !clr) begin
          for (int k = 0; k < 4; k++)
            if (!pv[g][k]) begin
              pv[g][k] = 1; pdue[g][k] = cyc + MS[g]; pp[g][k] = prod_of(g);
              break;
            end
        end
        for (int k = 0; k < 4; k++)
          if (pv[g][k] && pdue[g][k] == cyc) begin
            ret = 1; rp = pp[g][k]; pv[g][k] = 0;
          end
        if (clr) begin
          for (int k = 0; k < 4; k++) pv[g][k] = 0;
          m_acc[g] = 0; m_ovf[g] = 0;
        end else if (WrEn) begin
          m_acc[g] = fit(cin_of(g) + rp, g, of);
          m_ovf[g] = of;
        end else if (ret) begin
          m_acc[g] = fit(m_acc[g] + rp, g, of);
          m_ovf[g] = m_ovf[g] | of;
        end
      end
    end
    if (rst) begin m_a = 0; m_b = 0; end
    else if (en) begin m_a = Ain; m_b = Bin; end
    cyc++;
  endfunction

  // every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < N; g++) begin
        bit mb;
        logic [15:0] e16;
        mb = 0;
        for (int k = 0; k < 4; k++) mb = mb | pv[g][k];
        e16 = m_acc[g][15:0];
        check($sformatf("cyc%0d aout%0d", cyc, g), aout[g], m_a);
        check($sformatf("cyc%0d bout%0d", cyc, g), bout[g], m_b);
        check($sformatf("cyc%0d cout%0d", cyc, g), cout[g], e16);
        check($sformatf("cyc%0d ovf%0d", cyc, g), ovf[g], m_ovf[g]);
        check($sformatf("cyc%0d busy%0d", cyc, g), busy[g], mb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    en = 0; WrEn = 0; clr = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; en = 1; WrEn = 1; clr = 0; Ain = 8'd5; Bin = 8'd7; Cin = 16'd9;
    tick();
    chk_en = 1;
    tick();
    for (int g = 0; g < N; g++) begin
      check($sformatf("reset aout%0d", g), aout[g], 0);
      check($sformatf("reset cout%0d", g), cout[g], 0);
      check($sformatf("reset ovf%0d", g), ovf[g], 0);
      check($sformatf("reset busy%0d", g), busy[g], 0);
    end
    rst = 0;
    idle(1);

    // preload 100 then 3 * -4
    WrEn = 1; Cin = 16'd100; tick();
    WrEn = 0; en = 1; Ain = 8'd3; Bin = 8'hFC; tick();
    check("basic aout0", aout[0], 3);
    check("basic bout0", bout[0], 8'hFC);
    check("basic cout0", cout[0], 88);
    check("basic ovf0", ovf[0], 0);
    check("basic model0", m_acc[0], 88);
    check("basic model4", m_acc[4], 856);
    idle(4);

    // overflow from 32700 + 100
    WrEn = 1; Cin = 16'd32700; tick();
    WrEn = 0; en = 1; Ain = 8'd10; Bin = 8'd10; tick();
    check("sat cout0", cout[0], 32767);
    check("sat ovf0", ovf[0], 1);
    check("wrap cout1", cout[1], 16'h8020);
    check("wrap ovf1", ovf[1], 1);
    check("wrap model1", m_acc[1], -32736);
    Ain = 8'd1; Bin = 8'd1; tick();
    check("sticky ovf0", ovf[0], 1);
    check("sticky ovf1", ovf[1], 1);
    check("sticky cout1", cout[1], 16'h8021);
    idle(4);

    // two-stage pipeline, three back-to-back launches
    WrEn = 1; Cin = 16'd0; tick();
    WrEn = 0; en = 1; Ain = 8'd1; Bin = 8'd2; tick();
    check("ms2 k busy", busy[2], 1);
    check("ms2 k cout", cout[2], 0);
    Ain = 8'd3; Bin = 8'd4; tick();
    check("ms2 k+1 busy", busy[2], 1);
    Ain = 8'd5; Bin = 8'd6; tick();
    check("ms2 k+2 cout", cout[2], 2);
    check("ms2 k+2 busy", busy[2], 1);
    en = 0; tick();
    check("ms2 k+3 cout", cout[2], 14);
    check("ms2 k+3 busy", busy[2], 1);
    tick();
    check("ms2 k+4 cout", cout[2], 44);
    check("ms2 k+4 busy", busy[2], 0);
    check("ms2 model", m_acc[2], 44);
    idle(3);

    // one-stage: retiring product collides with preload
    en = 1; Ain = 8'd2; Bin = 8'd3; tick();
    en = 0; WrEn = 1; Cin = 16'd50; tick();
    check("collide cout3", cout[3], 56);
    WrEn = 0;
    en = 1; Ain = 8'd1; Bin = 8'd1; tick();
    Ain = 8'd2; Bin = 8'd2; tick();
    clr = 1; Ain = 8'd3; Bin = 8'd3; tick();
    check("clr cout3", cout[3], 0);
    check("clr busy3", busy[3], 0);
    check("clr cout2", cout[2], 0);
    check("clr busy2", busy[2], 0);
    check("clr aout3", aout[3], 3);
    idle(3);
    check("after clr cout3", cout[3], 0);
    check("after clr cout2", cout[2], 0);

    // unsigned 255*255 twice
    clr = 1; tick();
    clr = 0; en = 1; Ain = 8'hFF; Bin = 8'hFF; tick();
    check("uns cout4", cout[4], 65025);
    check("uns ovf4", ovf[4], 0);
    tick();
    check("uns sat cout4", cout[4], 65535);
    check("uns sat ovf4", ovf[4], 1);
    check("uns model4", m_acc[4], 65535);
    idle(4);

    // mixed directed table, model-checked every cycle
    for (int i = 0; i < 24; i++) begin
      Ain = 8'(i * 37 + 5); Bin = 8'(200 - i * 13); Cin = 16'(i * 1234 + 30000);
      en = (i % 3) != 0; WrEn = (i % 7) == 3; clr = (i % 11) == 5;
      tick();
    end

    // reset with products in flight
    en = 1; WrEn = 0; clr = 0; Ain = 8'd9; Bin = 8'd9; tick();
    rst = 1; tick();
    rst = 0; en = 0;
    for (int g = 0; g < N; g++) begin
      check($sformatf("midrst busy%0d", g), busy[g], 0);
      check($sformatf("midrst cout%0d", g), cout[g], 0);
    end
    idle(4);
    check("midrst late cout2", cout[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
